// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: PRGA state encoding, sizes and the plaintext ASCII test.
package rc4_pkg;

    localparam int unsigned S_SIZE          = 256;
    localparam int unsigned MSG_LEN_DEFAULT = 32;

    localparam logic [7:0] ASCII_LO    = 8'h61;
    localparam logic [7:0] ASCII_HI    = 8'h7A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [3:0] {
        StIdle,
        StRdSi,
        StWaitSi,
        StRdSj,
        StWaitSj,
        StWrSi,
        StWrSj,
        StRdF,
        StWaitF,
        StWrDec,
        StDone
    } prga_state_t;

    // Accepted plaintext: lower-case letters or space.
    function automatic logic ascii_ok(input logic [7:0] b);
        return ((b >= ASCII_LO) && (b <= ASCII_HI)) || (b == ASCII_SPACE);
    endfunction

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA stage: walks the shuffled S RAM, produces one keystream byte per
// message byte and writes enc ^ keystream into the decrypted-message RAM.
// Optional plaintext ASCII check with early abort: define PRGA_ASCII_CHECK_EN.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int unsigned MSG_LEN = MSG_LEN_DEFAULT,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        s_addr,
    output logic [7:0]        s_wdata,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] enc_addr,
    input  logic [7:0]        enc_q,
    output logic [ADDR_W-1:0] dec_addr,
    output logic [7:0]        dec_wdata,
    output logic              dec_wren,
    output logic              busy,
    output logic              done,
    output logic              key_invalid
);

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(MSG_LEN - 1);

    prga_state_t       state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        plain;
    logic              abort;

    assign plain = f_q ^ enc_q;

`ifdef PRGA_ASCII_CHECK_EN
    logic kinv_q, kinv_d;

    assign abort       = !ascii_ok(plain);
    assign key_invalid = kinv_q;

    // Sticky invalid-key flag, cleared by reset or a new start.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            kinv_q <= 1'b0;
        end else begin
            kinv_q <= kinv_d;
        end
    end
`else
    assign abort       = 1'b0;
    assign key_invalid = 1'b0;
`endif

    // enc_addr follows k so enc_q has settled long before WR_DEC.
    assign enc_addr = k_q;
    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q <= StIdle;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= '0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            f_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
        end
    end

    // Next-state logic and memory port drive.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        si_d      = si_q;
        sj_d      = sj_q;
        f_d       = f_q;
        s_addr    = 8'd0;
        s_wdata   = 8'd0;
        s_wren    = 1'b0;
        dec_addr  = '0;
        dec_wdata = 8'd0;
        dec_wren  = 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
        kinv_d    = kinv_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRdSi;
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
`ifdef PRGA_ASCII_CHECK_EN
                    kinv_d  = 1'b0;
`endif
                end
            end
            StRdSi: begin
                s_addr  = i_q;
                state_d = StWaitSi;
            end
            StWaitSi: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = StRdSj;
            end
            StRdSj: begin
                s_addr  = j_q;
                state_d = StWaitSj;
            end
            StWaitSj: begin
                sj_d    = s_q;
                state_d = StWrSi;
            end
            StWrSi: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                s_wren  = 1'b1;
                state_d = StWrSj;
            end
            StWrSj: begin
                // When i == j this rewrites the same value: S is unchanged.
                s_addr  = j_q;
                s_wdata = si_q;
                s_wren  = 1'b1;
                state_d = StRdF;
            end
            StRdF: begin
                s_addr  = si_q + sj_q;
                state_d = StWaitF;
            end
            StWaitF: begin
                f_d     = s_q;
                state_d = StWrDec;
            end
            StWrDec: begin
                dec_addr  = k_q;
                dec_wdata = plain;
                dec_wren  = 1'b1;
                if (abort) begin
`ifdef PRGA_ASCII_CHECK_EN
                    kinv_d  = 1'b1;
`endif
                    state_d = StDone;
                end else if (k_q == K_LAST) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + 1'b1;
                    i_d     = i_q + 8'd1;
                    state_d = StRdSi;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Self-checking bench for prga_decrypt (MSG_LEN=256 so i wraps within one run).
module tb_prga_decrypt;

    localparam int unsigned MSG_LEN = 256;
    localparam int unsigned ADDR_W  = 8;
    localparam int          BOUND   = 3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        s_addr, s_wdata, s_q;
    logic              s_wren;
    logic [ADDR_W-1:0] enc_addr, dec_addr;
    logic [7:0]        enc_q, dec_wdata;
    logic              dec_wren, busy, done, key_invalid;

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_q(s_q),
        .enc_addr(enc_addr), .enc_q(enc_q),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren),
        .busy(busy), .done(done), .key_invalid(key_invalid)
    );

    // Memories around the DUT.
    logic [7:0] sram    [256];
    logic [7:0] s_init  [256];
    logic [7:0] enc_rom [256];
    logic [7:0] dec_mem [256];
    logic       load_s = 1'b0;
    logic       clr_log = 1'b0;
    int         dec_writes = 0;
    int         any_writes = 0;
    logic       both_hi = 1'b0;

    always @(posedge clk) begin
        if (load_s) begin
            for (int n = 0; n < 256; n++) sram[n] <= s_init[n];
        end else if (s_wren) begin
            sram[s_addr] <= s_wdata;
        end
        s_q   <= sram[s_addr];
        enc_q <= enc_rom[enc_addr];
    end

    always @(posedge clk) begin
        if (clr_log) begin
            dec_writes <= 0;
            any_writes <= 0;
            both_hi    <= 1'b0;
        end else begin
            if (dec_wren) begin
                dec_mem[dec_addr] <= dec_wdata;
                dec_writes        <= dec_writes + 1;
            end
            if (dec_wren || s_wren) any_writes <= any_writes + 1;
            if (dec_wren && s_wren) both_hi <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: textbook RC4 PRGA over arrays.
    logic [7:0] m_s   [256];
    logic [7:0] m_enc [256];
    logic [7:0] m_dec [256];
    int         m_n;
    logic       m_inv;

    function automatic logic tb_ascii(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    task automatic model_run(input bit use_check);
        logic [7:0] i, j, t, f, p;
        i = 8'd0;
        j = 8'd0;
        m_n = 0;
        m_inv = 1'b0;
        for (int n = 0; n < int'(MSG_LEN); n++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
            f = m_s[m_s[i] + m_s[j]];
            p = f ^ m_enc[n];
            m_dec[n] = p;
            m_n++;
`ifdef PRGA_ASCII_CHECK_EN
            if (use_check && !tb_ascii(p)) begin
                m_inv = 1'b1;
                break;
            end
`endif
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        clr_log = 1'b1;
        @(negedge clk);
        clr_log = 1'b0;
    endtask

    // Load S RAM and the model copy from s_init; model enc from enc_rom.
    task automatic load_all();
        for (int n = 0; n < 256; n++) begin
            m_s[n]   = s_init[n];
            m_enc[n] = enc_rom[n];
        end
        @(negedge clk);
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
    endtask

    // enc chosen so every plaintext byte is a random valid character.
    task automatic make_ascii_enc();
        logic [7:0] c;
        for (int n = 0; n < 256; n++) begin
            m_s[n]   = s_init[n];
            m_enc[n] = 8'h00;
        end
        model_run(1'b0);
        for (int n = 0; n < 256; n++) begin
            c = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'($urandom_range(8'h61, 8'h7A));
            enc_rom[n] = m_dec[n] ^ c;
        end
    endtask

    task automatic perm_s();
        logic [7:0] t;
        int r;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        for (int n = 255; n > 0; n--) begin
            r = $urandom_range(0, n);
            t = s_init[n];
            s_init[n] = s_init[r];
            s_init[r] = t;
        end
    endtask

    // Pulse start (sampled at edge E0) and count edges until done is seen.
    task automatic start_and_wait(output int cyc, output bit to);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        to  = 1'b1;
        while (cyc < BOUND) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic diff_results(output int dec_diff, output int s_diff);
        dec_diff = 0;
        s_diff   = 0;
        for (int n = 0; n < m_n; n++) if (dec_mem[n] !== m_dec[n]) dec_diff++;
        for (int n = 0; n < 256; n++) if (sram[n] !== m_s[n]) s_diff++;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outs = {s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren,
                busy, done, key_invalid};
        n_cmp++;
        if (outs !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_identity();
        int cyc, dd, sd;
        bit to;
        for (int n = 0; n < 256; n++) begin
            s_init[n]  = 8'(n);
            enc_rom[n] = 8'h00;
        end
        load_all();
        model_run(1'b1);
        clear_log();
        start_and_wait(cyc, to);
        diff_results(dd, sd);
        n_cmp++;
        if (to || cyc != 9 * m_n) begin
            n_bad++;
            $display("FAIL identity_latency: got %0d cycles (timeout=%0d) want %0d", cyc, to, 9 * m_n);
        end
        n_cmp++;
        if (dec_mem[0] !== 8'h02) begin
            n_bad++;
            $display("FAIL identity_dec0: got %h want 02", dec_mem[0]);
        end
        if (m_n >= 4) begin
            n_cmp++;
            if ({dec_mem[1], dec_mem[2], dec_mem[3]} !== 24'h05070D) begin
                n_bad++;
                $display("FAIL identity_dec123: got %h %h %h want 05 07 0d",
                         dec_mem[1], dec_mem[2], dec_mem[3]);
            end
        end
        n_cmp++;
        if (dd != 0 || sd != 0) begin
            n_bad++;
            $display("FAIL identity_model: dec diffs %0d s diffs %0d want 0", dd, sd);
        end
        n_cmp++;
        if (dec_writes != m_n || key_invalid !== m_inv) begin
            n_bad++;
            $display("FAIL identity_count: writes %0d kinv %b want %0d %b",
                     dec_writes, key_invalid, m_n, m_inv);
        end
        n_cmp++;
        if (both_hi !== 1'b0) begin
            n_bad++;
            $display("FAIL identity_wren_overlap: got 1 want 0");
        end
    endtask

    task automatic test_ascii();
        int cyc, dd, sd;
        bit to;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        make_ascii_enc();
        enc_rom[0] = 8'h63;
        enc_rom[1] = 8'h64;
        enc_rom[2] = 8'h66;
        enc_rom[3] = 8'h6C;
        load_all();
        model_run(1'b1);
        clear_log();
        start_and_wait(cyc, to);
        diff_results(dd, sd);
        n_cmp++;
        if ({dec_mem[0], dec_mem[1], dec_mem[2], dec_mem[3]} !== 32'h61616161) begin
            n_bad++;
            $display("FAIL ascii_aaaa: got %h%h%h%h want 61616161",
                     dec_mem[0], dec_mem[1], dec_mem[2], dec_mem[3]);
        end
        n_cmp++;
        if (to || cyc != 9 * int'(MSG_LEN) || key_invalid !== 1'b0 || dec_writes != 256) begin
            n_bad++;
            $display("FAIL ascii_full: cyc %0d kinv %b writes %0d want %0d 0 256",
                     cyc, key_invalid, dec_writes, 9 * MSG_LEN);
        end
        n_cmp++;
        if (dd != 0 || sd != 0) begin
            n_bad++;
            $display("FAIL ascii_model: dec diffs %0d s diffs %0d want 0", dd, sd);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, dd, sd;
        bit to;
        logic [63:0] outs;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        make_ascii_enc();
        load_all();
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        n_cmp++;
        if (s_wren !== 1'b1 || s_addr !== 8'd2) begin
            n_bad++;
            $display("FAIL midreset_wrsi: s_wren %b s_addr %h want 1 02", s_wren, s_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        outs = {s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren,
                busy, done, key_invalid};
        n_cmp++;
        if (outs !== 64'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h want 0", outs);
        end
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (any_writes != 0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_quiet: writes %0d busy %b done %b want 0 0 0",
                     any_writes, busy, done);
        end
        load_all();
        model_run(1'b1);
        clear_log();
        start_and_wait(cyc, to);
        diff_results(dd, sd);
        n_cmp++;
        if (to || cyc != 9 * m_n || dd != 0 || sd != 0 || dec_writes != m_n) begin
            n_bad++;
            $display("FAIL midreset_restart: cyc %0d dd %0d sd %0d writes %0d want %0d 0 0 %0d",
                     cyc, dd, sd, dec_writes, 9 * m_n, m_n);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, dd, sd;
        bit to;
        perm_s();
        make_ascii_enc();
        load_all();
        model_run(1'b1);
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        to  = 1'b1;
        while (cyc < BOUND) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 100) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        diff_results(dd, sd);
        n_cmp++;
        if (to || cyc != 9 * m_n || dd != 0 || sd != 0) begin
            n_bad++;
            $display("FAIL busy_start_ignored: cyc %0d dd %0d sd %0d want %0d 0 0",
                     cyc, dd, sd, 9 * m_n);
        end
        // Restart from DONE on the S left behind; model continues from its own S.
        model_run(1'b1);
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1 || key_invalid !== 1'b0) begin
            n_bad++;
            $display("FAIL done_restart: done %b busy %b kinv %b want 0 1 0",
                     done, busy, key_invalid);
        end
        cyc = 0;
        to  = 1'b1;
        while (cyc < BOUND) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        diff_results(dd, sd);
        n_cmp++;
        if (to || cyc != 9 * m_n || dd != 0 || sd != 0 || key_invalid !== m_inv) begin
            n_bad++;
            $display("FAIL done_rerun: cyc %0d dd %0d sd %0d kinv %b want %0d 0 0 %b",
                     cyc, dd, sd, key_invalid, 9 * m_n, m_inv);
        end
    endtask

    task automatic test_zero_s();
        int cyc, dd, sd, eq;
        bit to;
        for (int n = 0; n < 256; n++) begin
            s_init[n]  = 8'h00;
            enc_rom[n] = ($urandom_range(0, 3) == 0) ? 8'h20 : 8'($urandom_range(8'h61, 8'h7A));
        end
        load_all();
        model_run(1'b1);
        clear_log();
        start_and_wait(cyc, to);
        diff_results(dd, sd);
        eq = 0;
        for (int n = 0; n < 256; n++) if (dec_mem[n] === enc_rom[n]) eq++;
        n_cmp++;
        if (to || cyc != 2304) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d (timeout=%0d) want 2304", cyc, to);
        end
        n_cmp++;
        if (eq != 256 || dec_writes != 256 || dd != 0 || sd != 0) begin
            n_bad++;
            $display("FAIL zero_passthru: equal %0d writes %0d dd %0d sd %0d want 256 256 0 0",
                     eq, dec_writes, dd, sd);
        end
    endtask

    task automatic test_random();
        int cyc, dd, sd;
        bit to;
        for (int it = 0; it < 3; it++) begin
            perm_s();
            for (int n = 0; n < 256; n++) enc_rom[n] = 8'($urandom);
            if (it == 2) make_ascii_enc();
            load_all();
            model_run(1'b1);
            clear_log();
            start_and_wait(cyc, to);
            diff_results(dd, sd);
            n_cmp++;
            if (to || cyc != 9 * m_n || dd != 0 || sd != 0 || dec_writes != m_n
                || key_invalid !== m_inv || both_hi !== 1'b0) begin
                n_bad++;
                $display("FAIL random_%0d: cyc %0d dd %0d sd %0d writes %0d kinv %b want %0d 0 0 %0d %b",
                         it, cyc, dd, sd, dec_writes, key_invalid, 9 * m_n, m_n, m_inv);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int n = 0; n < 256; n++) begin
            s_init[n]  = 8'(n);
            enc_rom[n] = 8'h00;
            dec_mem[n] = 8'h00;
        end
        test_reset();
        test_identity();
        test_ascii();
        test_reset_mid();
        test_back_to_back();
        test_zero_s();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
